instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- Fetch stage directly upstream of the opcode/funct control decoder in the single-cycle-style MIPS datapath.
- Holds the PC and issues one-outstanding-request fetches to instruction memory over a req/ack handshake.
- Presents the fetched word plus its opcode/funct fields to decode under a valid/ready handshake.
- Computes the next PC from the decoder's isjump/isbranch outputs and the datapath's branch condition. Supports J, JAL, JR, BNE and sequential flow.

Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on reset; word-aligned.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; equals pc.
- imem_rdata  in  32  instruction word; valid when imem_ack=1.
- imem_ack  in  1  memory completion strobe; one cycle per request.
- instr  out  32  instruction register contents.
- opcode  out  6  instr[31:26], to the control decoder.
- funct  out  6  instr[5:0], to the control decoder.
- instr_valid  out  1  instr holds an unconsumed instruction.
- instr_ready  in  1  decode/execute consumes instr this cycle.
- isjump  in  1  control decoder: current instr is J, JAL or JR.
- isbranch  in  1  control decoder: current instr is BNE.
- branch_ne  in  1  datapath: rs != rt for the current BNE (ALU SUB result nonzero).
- jr_target  in  32  rs register value for JR.
- pc  out  32  address of the instruction held in instr.
- pc_plus4  out  32  pc + 4; link value for JAL.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=RESET_PC, instr=0, imem_req=0, instr_valid=0.
  - opcode and funct read 0; pc_plus4 reads RESET_PC+4.
- States and transitions:
  - IDLE: imem_req=0. Always goes to REQ on the next edge. The first request is asserted exactly one cycle after rst_n rises.
  - REQ: imem_req=1, imem_addr=pc. If imem_ack=1, load instr<=imem_rdata and go to HOLD. Zero-wait ack, in the same cycle req first rises, is legal. Otherwise stay in REQ with req and addr held stable.
  - HOLD: imem_req=0, instr_valid=1. While instr_ready=0, instr, pc and the outputs stay stable. When instr_ready=1, pc<=next_pc and the block goes to REQ. The next request therefore starts one cycle after consumption.
- Handshakes:
  - instr_valid is a registered output and is high only in HOLD.
  - instr_ready is ignored outside HOLD.
  - imem_ack is ignored outside REQ; a stray ack is dropped, not captured.
- Next-PC selection, evaluated in HOLD using the current instr. Priority top to bottom:
  1. isjump && opcode==6'h00 (JR): {jr_target[31:2],2'b00}; low bits are forced to zero.
  2. isjump (J 6'h02, JAL 6'h03): {pc_plus4[31:28], instr[25:0], 2'b00}.
  3. isbranch && branch_ne: pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}); the immediate is sign-extended.
  4. Otherwise: pc_plus4.
- Arithmetic:
  - All arithmetic is 32-bit modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0.
  - A negative branch offset may wrap below 0; no fault is raised.
- isjump and isbranch both high: the jump wins (priority above). This is an illegal decoder output but is defined.
- pc_plus4 is combinational from pc.
- Reset during REQ or HOLD: the block returns to IDLE immediately and the held instruction is discarded. Memory must abort the pending access. The first ack after reset is honoured only in REQ.

Test Plan:
1. Reset then sequential fetch: RESET_PC=0, ack 1 cycle after each req, instr_ready=1. Required: imem_addr = 0, 4, 8; instr_valid pulses once per word; instr matches the memory word each time.
2. Wait states and backpressure: ack delayed 3 cycles and instr_ready held low 4 cycles. Required: imem_addr stable throughout REQ; instr and pc stable throughout HOLD; no second req until consumed.
3. J and JAL: pc=32'h0040_0010, instr=32'h0810_0000 (J), isjump=1. Required: next imem_addr=32'h0040_0000. The same with opcode 6'h03 gives pc_plus4=32'h0040_0014 during HOLD.
4. JR: instr opcode 0, funct 6'h08, isjump=1, jr_target=32'h0000_1237. Required: next imem_addr=32'h0000_1234.
5. BNE: pc=32'h100, imm=16'hFFFE, isbranch=1.
   - branch_ne=1: next addr=32'h0FC.
   - branch_ne=0: next addr=32'h104.
6. Reset mid-operation: assert rst_n=0 during REQ, with ack arriving in the same cycle. Required: instr stays 0; instr_valid=0; after release, the first imem_addr=RESET_PC.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: holds the PC, fetches one word at a time from
// instruction memory over req/ack, presents it to decode over valid/ready,
// and selects the next PC (sequential, J/JAL, JR, BNE).
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        isjump,
  input  logic        isbranch,
  input  logic        branch_ne,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] next_pc;
  logic [31:0] branch_off;
  logic        unused_bits;

  // JR targets are word aligned, so the two low bits of rs are dropped.
  assign unused_bits = ^jr_target[1:0];

  assign imem_addr  = pc;
  assign opcode     = instr[31:26];
  assign funct      = instr[5:0];
  assign pc_plus4   = pc + 32'd4;
  assign branch_off = {{14{instr[15]}}, instr[15:0], 2'b00};

  // Next-PC select for the held instruction; jumps outrank branches.
  always_comb begin
    next_pc = pc_plus4;
    if (isjump && (opcode == 6'h00)) begin
      next_pc = {jr_target[31:2], 2'b00};
    end else if (isjump) begin
      next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    end else if (isbranch && branch_ne) begin
      next_pc = pc_plus4 + branch_off;
    end else begin
      next_pc = pc_plus4;
    end
  end

  // Fetch FSM with registered request/valid outputs and PC/instruction state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= 32'h0000_0000;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state       <= REQ;
          imem_req    <= 1'b1;
          instr_valid <= 1'b0;
        end
        REQ: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            state       <= HOLD;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end else begin
            state       <= REQ;
            imem_req    <= 1'b1;
            instr_valid <= 1'b0;
          end
        end
        HOLD: begin
          // Stray acks are ignored here; only consumption moves us on.
          if (instr_ready) begin
            pc          <= next_pc;
            state       <= REQ;
            imem_req    <= 1'b1;
            instr_valid <= 1'b0;
          end else begin
            state       <= HOLD;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a small memory responder driven from
// one initial block, with a scoreboard of expected fetched words.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0000_0000;
  logic        imem_ack = 1'b0;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        isjump = 1'b0;
  logic        isbranch = 1'b0;
  logic        branch_ne = 1'b0;
  logic [31:0] jr_target = 32'h0000_0000;
  logic [31:0] pc;
  logic [31:0] pc_plus4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
  } fetch_t;

  fetch_t sb[$];
  fetch_t cur;
  int     errors = 0;
  int     checks = 0;

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .instr(instr), .opcode(opcode), .funct(funct),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .isjump(isjump), .isbranch(isbranch), .branch_ne(branch_ne),
    .jr_target(jr_target), .pc(pc), .pc_plus4(pc_plus4)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait for a request, hold ack off for 'delay' cycles, then return 'word'.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] word,
                       input int delay, input logic [31:0] plus4_exp);
    fetch_t e;
    int n;
    n = 0;
    while (!imem_req && n < 20) begin
      step();
      n++;
    end
    chk("req_seen", {31'd0, imem_req}, 32'd1);
    chk("imem_addr", imem_addr, addr);
    chk("valid_in_req", {31'd0, instr_valid}, 32'd0);
    for (int i = 0; i < delay; i++) begin
      step();
      chk("req_held", {31'd0, imem_req}, 32'd1);
      chk("addr_held", imem_addr, addr);
    end
    imem_rdata = word;
    imem_ack = 1'b1;
    sb.push_back('{addr, word});
    step();
    imem_ack = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    n = 0;
    while (!instr_valid && n < 20) begin
      step();
      n++;
    end
    chk("valid_seen", {31'd0, instr_valid}, 32'd1);
    e = sb.pop_front();
    chk("instr", instr, e.word);
    chk("pc", pc, e.addr);
    chk("opcode", {26'd0, opcode}, {26'd0, e.word[31:26]});
    chk("funct", {26'd0, funct}, {26'd0, e.word[5:0]});
    chk("pc_plus4", pc_plus4, plus4_exp);
    chk("req_in_hold", {31'd0, imem_req}, 32'd0);
    cur = e;
  endtask

  // Stall 'stall' cycles (with a stray ack on the first), then consume.
  task automatic consume(input int stall, input logic j, input logic b,
                         input logic bne, input logic [31:0] jrt);
    for (int i = 0; i < stall; i++) begin
      if (i == 0) begin
        imem_ack = 1'b1;
        imem_rdata = 32'h1111_1111;
      end
      step();
      imem_ack = 1'b0;
      chk("instr_stable", instr, cur.word);
      chk("pc_stable", pc, cur.addr);
      chk("valid_stable", {31'd0, instr_valid}, 32'd1);
      chk("no_req_stall", {31'd0, imem_req}, 32'd0);
    end
    isjump = j;
    isbranch = b;
    branch_ne = bne;
    jr_target = jrt;
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    isjump = 1'b0;
    isbranch = 1'b0;
    branch_ne = 1'b0;
    jr_target = 32'h0000_0000;
    chk("valid_after_consume", {31'd0, instr_valid}, 32'd0);
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_pc_plus4", pc_plus4, 32'd4);
    chk("rst_opcode", {26'd0, opcode}, 32'd0);
    chk("rst_funct", {26'd0, funct}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("first_req_one_cycle", {31'd0, imem_req}, 32'd1);

    // Sequential fetch 0, 4, 8
    fetch(32'h0000_0000, 32'h0000_0020, 1, 32'h0000_0004);
    consume(0, 1'b0, 1'b0, 1'b0, 32'h0);
    fetch(32'h0000_0004, 32'h0000_0022, 1, 32'h0000_0008);
    consume(0, 1'b0, 1'b0, 1'b0, 32'h0);
    // Wait states + backpressure, J to 0x0040_0010
    fetch(32'h0000_0008, 32'h0810_0004, 3, 32'h0000_000C);
    consume(4, 1'b1, 1'b0, 1'b0, 32'h0);
    // J at 0x0040_0010 -> 0x0040_0000
    fetch(32'h0040_0010, 32'h0810_0000, 1, 32'h0040_0014);
    consume(0, 1'b1, 1'b0, 1'b0, 32'h0);
    // JAL at 0x0040_0000 -> 0x0040_0010
    fetch(32'h0040_0000, 32'h0C10_0004, 1, 32'h0040_0004);
    consume(0, 1'b1, 1'b0, 1'b0, 32'h0);
    // JAL at 0x0040_0010: link value 0x0040_0014, -> 0x0040_0000
    fetch(32'h0040_0010, 32'h0C10_0000, 1, 32'h0040_0014);
    consume(0, 1'b1, 1'b0, 1'b0, 32'h0);
    // JR with misaligned rs -> 0x1234
    fetch(32'h0040_0000, 32'h03E0_0008, 1, 32'h0040_0004);
    consume(0, 1'b1, 1'b0, 1'b0, 32'h0000_1237);
    // JR -> 0x100
    fetch(32'h0000_1234, 32'h0000_0008, 1, 32'h0000_1238);
    consume(0, 1'b1, 1'b0, 1'b0, 32'h0000_0100);
    // BNE taken, imm -2 -> 0x0FC
    fetch(32'h0000_0100, 32'h1440_FFFE, 1, 32'h0000_0104);
    consume(0, 1'b0, 1'b1, 1'b1, 32'h0);
    // BNE not taken at 0x0FC -> 0x100
    fetch(32'h0000_00FC, 32'h1440_FFFE, 1, 32'h0000_0100);
    consume(0, 1'b0, 1'b1, 1'b0, 32'h0);
    // BNE not taken at 0x100 -> 0x104
    fetch(32'h0000_0100, 32'h1440_FFFE, 1, 32'h0000_0104);
    consume(0, 1'b0, 1'b1, 1'b0, 32'h0);
    // isjump and isbranch both high: jump to 0x100 wins over branch 0x208
    fetch(32'h0000_0104, 32'h0800_0040, 1, 32'h0000_0108);
    consume(0, 1'b1, 1'b1, 1'b1, 32'h0);
    // JR to top of memory
    fetch(32'h0000_0100, 32'h0000_0008, 2, 32'h0000_0104);
    consume(0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF);
    // Wraparound: pc_plus4 of 0xFFFF_FFFC is 0
    fetch(32'hFFFF_FFFC, 32'h0000_0020, 1, 32'h0000_0000);
    consume(2, 1'b0, 1'b0, 1'b0, 32'h0);
    // Zero-wait ack at address 0
    fetch(32'h0000_0000, 32'hABCD_0020, 0, 32'h0000_0004);
    consume(0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Reset during REQ with an ack in the same cycle
    chk("pre_reset_req", {31'd0, imem_req}, 32'd1);
    chk("pre_reset_addr", imem_addr, 32'h0000_0004);
    imem_rdata = 32'h5555_AAAA;
    imem_ack = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_instr", instr, 32'd0);
    chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
    chk("mid_rst_pc", pc, 32'd0);
    step();
    chk("rst_hold_instr", instr, 32'd0);
    rst_n = 1'b1;
    imem_ack = 1'b0;
    step();
    chk("post_rst_req", {31'd0, imem_req}, 32'd1);
    chk("post_rst_addr", imem_addr, 32'h0000_0000);
    chk("post_rst_instr", instr, 32'd0);
    chk("post_rst_valid", {31'd0, instr_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
